spm_mul_param: RTL and testbench
================================

SPM_MUL_PARAM -- requirements
Module: spm_mul_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; legal range 4..64.
REQ-002 SHALL have parameter SIGNED_EN, default 1; when 0, signed mode is disabled and mode_signed is ignored.
REQ-003 SHALL have the port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-004 SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have the port start, input, 1 bit: request a new multiply.
REQ-006 SHALL have the port mode_signed, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 SHALL have the port mc, input, WIDTH bits: multiplicand.
REQ-008 SHALL have the port mp, input, WIDTH bits: multiplier.
REQ-009 SHALL have the port prod_sel, input, 1 bit: 0 = low half on prod, 1 = high half on prod; combinational select, not sampled.
REQ-010 SHALL have the port busy, output, 1 bit: operation in progress.
REQ-011 SHALL have the port done, output, 1 bit: result valid.
REQ-012 SHALL have the port prod, output, WIDTH bits: selected half of the product.
REQ-013 SHALL have the port prod_full, output, 2*WIDTH bits: full product.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 SHALL, in IDLE or DONE with start=1 at edge k: latch mc, mp and mode_signed, clear the accumulator, load bit counter=0, and enter RUN at k+1.
REQ-016 SHALL, in RUN, retire one multiplier bit per cycle (LSB first) by shift-add of the latched mc into a 2*WIDTH accumulator.
REQ-017 SHALL, in signed mode, subtract (not add) the sign-extended mc on the final bit (mp MSB); in unsigned mode all steps add with zero extension.
REQ-018 SHALL assert busy for exactly WIDTH cycles, k+1..k+WIDTH; done SHALL rise at k+WIDTH+1, giving latency WIDTH+1 cycles from the start edge.
REQ-019 SHALL hold done and prod_full stable in DONE until the next accepted start; done SHALL deassert the cycle after that start.
REQ-020 SHALL ignore start while in RUN, with no effect on the operation, its latched operands or its timing.
REQ-021 SHALL ignore changes on mc, mp and mode_signed after the start edge.
REQ-022 SHALL drive prod = prod_full[WIDTH-1:0] when prod_sel=0 and prod_full[2*WIDTH-1:WIDTH] when prod_sel=1.
REQ-023 SHALL produce a result equal to the exact mathematical product mod 2^(2*WIDTH), including the signed corner case (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
REQ-024 SHALL produce prod_full=0 when either operand is 0, still taking the full latency (no early termination).
REQ-025 SHALL never assert busy and done in the same cycle.

Reset
REQ-026 SHALL, on rst_n=0, immediately (asynchronously) force IDLE, busy=0, done=0, accumulator=0, counter=0, and latched operands=0; prod and prod_full therefore read 0.
REQ-027 SHALL, on reset assertion mid-RUN, abandon the operation without asserting done; the first start after rst_n rises SHALL be accepted normally.

Structure
REQ-028 SHALL place the FSM state enum, the default WIDTH constant and a counter-width function (clog2 of WIDTH) in shared package spm_pkg.
REQ-029 SHALL use one sub-module, spm_addsub: a (WIDTH+1)-bit add/subtract unit with a sub control input, instantiated once for the per-cycle partial-product step.
REQ-030 SHALL keep all state in a single clocked process with asynchronous reset; the output mux SHALL be combinational.

Verification
REQ-031 SHALL cover: WIDTH=32, unsigned, mc=0xFFFFFFFF, mp=0xFFFFFFFF, start pulse -> done at cycle 33, prod_full=0xFFFFFFFE00000001; prod_sel=1 -> prod=0xFFFFFFFE.
REQ-032 SHALL cover: WIDTH=8, signed, mc=0x80, mp=0x80 -> prod_full=0x4000; mc=0xFD (-3), mp=0x07 -> prod_full=0xFFEB (-21), done at cycle 9.
REQ-033 SHALL cover: start re-pulsed and mc/mp changed during RUN -> result and done timing unchanged from the original operands.
REQ-034 SHALL cover: rst_n pulled low at RUN cycle 5 -> busy=done=prod_full=0 immediately, no done pulse; a new start after release completes correctly.
REQ-035 SHALL cover: back-to-back operation with start asserted in the DONE state (3*5 then 7*9, unsigned) -> done low one cycle later, second result 63 after WIDTH+1 cycles.
REQ-036 SHALL cover: SIGNED_EN=0 with mode_signed=1, mc=mp=0xFF (WIDTH=8) -> prod_full=0xFE01 (unsigned result).

Source files
------------

// File: rtl/spm_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spm_pkg;

   // Default operand width when the top is instantiated without overrides.
   localparam int SPM_WIDTH_DEFAULT = 32;

   // Controller states: waiting, retiring multiplier bits, holding result.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } spm_state_t;

   // Bits needed to index one multiplier bit (0..w-1).
   function automatic int spm_cnt_width(input int w);
      return (w <= 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/spm_addsub.sv
// Add/subtract unit for one partial-product step: y = a + b, or a - b when sub=1.
// Latency: combinational.
// Backpressure: none.
module spm_addsub #(
   parameter int N = 33
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         sub,
   output logic [N-1:0] y
);

   // Single adder path; subtraction selected by the control input.
   always_comb begin
      y = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/spm_mul_param.sv
// Sequential shift-add multiplier, unsigned or two's-complement, one multiplier bit per cycle.
// Latency: WIDTH+1 cycles from the accepted start edge to done.
// Backpressure: start is ignored while busy; result held until the next accepted start.
module spm_mul_param
   import spm_pkg::*;
#(
   parameter int WIDTH     = SPM_WIDTH_DEFAULT,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               mode_signed,
   input  logic [WIDTH-1:0]   mc,
   input  logic [WIDTH-1:0]   mp,
   input  logic               prod_sel,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   prod,
   output logic [2*WIDTH-1:0] prod_full
);

   localparam int            CW   = spm_cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   spm_state_t         state_q;
   spm_state_t         state_d;
   logic [WIDTH-1:0]   mc_q;
   logic [WIDTH-1:0]   mp_q;
   logic               sgn_q;
   logic [CW-1:0]      cnt_q;
   logic [2*WIDTH-1:0] acc_q;

   logic               accept;
   logic               last;
   logic               sub;
   logic [WIDTH:0]     hi_ext;
   logic [WIDTH:0]     pp;
   logic [WIDTH:0]     sum;

   // Step operands: upper accumulator half extended by one bit (arithmetic in signed
   // mode), and the multiplicand gated by the current multiplier bit. The MSB of a
   // two's-complement multiplier carries negative weight, hence the final subtract.
   always_comb begin
      accept = start && (state_q != ST_RUN);
      last   = (cnt_q == LAST);
      sub    = sgn_q && last;
      hi_ext = {sgn_q & acc_q[2*WIDTH-1], acc_q[2*WIDTH-1:WIDTH]};
      pp     = mp_q[cnt_q] ? {sgn_q & mc_q[WIDTH-1], mc_q} : '0;
   end

   spm_addsub #(
      .N (WIDTH + 1)
   ) u_addsub (
      .a   (hi_ext),
      .b   (pp),
      .sub (sub),
      .y   (sum)
   );

   // All state: controller, latched operands, bit counter and accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mc_q    <= '0;
         mp_q    <= '0;
         sgn_q   <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            mc_q  <= mc;
            mp_q  <= mp;
            sgn_q <= SIGNED_EN & mode_signed;
            cnt_q <= '0;
            acc_q <= '0;
         end else if (state_q == ST_RUN) begin
            // The (WIDTH+1)-bit sum lands on top; the shift retires one product bit low.
            acc_q <= {sum, acc_q[WIDTH-1:1]};
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Next-state: start accepted from IDLE or DONE, RUN ends after the last bit.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last)  state_d = ST_DONE;
         ST_DONE: if (start) state_d = ST_RUN;
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs and the combinational product-half select.
   always_comb begin
      busy      = (state_q == ST_RUN);
      done      = (state_q == ST_DONE);
      prod_full = acc_q;
      prod      = prod_sel ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
   end

endmodule

// File: tb/tb_spm_mul_param.sv
// Directed bench: 32-bit unsigned, 8-bit signed and 8-bit signed-disabled multipliers.
// Latency: expected WIDTH+1 cycles start-to-done on every operation.
// Backpressure: start pulses during RUN must be ignored.
module tb_spm_mul_param;

   logic        clk;
   logic        rst_n;

   logic        start32, mode32, sel32;
   logic [31:0] mc32, mp32;
   logic        busy32, done32;
   logic [31:0] prod32;
   logic [63:0] full32;

   logic        start8, mode8, sel8;
   logic [7:0]  mc8, mp8;
   logic        busy8s, done8s, busy8u, done8u;
   logic [7:0]  prod8s, prod8u;
   logic [15:0] full8s, full8u;

   int n_chk;
   int n_pass;

   spm_mul_param #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (
      .clk (clk), .rst_n (rst_n), .start (start32), .mode_signed (mode32),
      .mc (mc32), .mp (mp32), .prod_sel (sel32),
      .busy (busy32), .done (done32), .prod (prod32), .prod_full (full32)
   );

   spm_mul_param #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
      .clk (clk), .rst_n (rst_n), .start (start8), .mode_signed (mode8),
      .mc (mc8), .mp (mp8), .prod_sel (sel8),
      .busy (busy8s), .done (done8s), .prod (prod8s), .prod_full (full8s)
   );

   spm_mul_param #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
      .clk (clk), .rst_n (rst_n), .start (start8), .mode_signed (mode8),
      .mc (mc8), .mp (mp8), .prod_sel (sel8),
      .busy (busy8u), .done (done8u), .prod (prod8u), .prod_full (full8u)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Pulse start on the 8-bit pair for one edge; returns one cycle after that edge.
   task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic sgn);
      @(negedge clk);
      mc8 = a; mp8 = b; mode8 = sgn; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
   endtask

   // Observe from cycle 1 after the start edge until done (bounded); disturb=1 re-pulses
   // start and scrambles the 8-bit operands mid-run.
   task automatic wait_done(input string tag, input int which, input int disturb, input int exp_lat);
      int lat;
      int nbusy;
      bit overlap;
      bit b;
      bit d;
      lat = 1; nbusy = 0; overlap = 1'b0;
      while (lat <= 60) begin
         b = (which == 32) ? busy32 : busy8s;
         d = (which == 32) ? done32 : done8s;
         if (lat == 1) chk({tag, "_accept"}, {b, d}, 2'b10);
         if (b && d) overlap = 1'b1;
         if (b) nbusy++;
         if (d) break;
         if (disturb == 1 && lat == 3) begin
            start8 = 1'b1; mc8 = 8'hFF; mp8 = 8'hFF; mode8 = 1'b1;
         end
         if (disturb == 1 && lat == 4) start8 = 1'b0;
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_busycyc"}, nbusy, exp_lat - 1);
      chk({tag, "_excl"}, overlap, 0);
   endtask

   initial begin
      bit saw_done;
      n_chk = 0; n_pass = 0;
      clk = 1'b0; rst_n = 1'b0;
      start32 = 0; mode32 = 0; sel32 = 0; mc32 = '0; mp32 = '0;
      start8 = 0; mode8 = 0; sel8 = 0; mc8 = '0; mp8 = '0;

      repeat (2) @(negedge clk);
      chk("rst_busy32", busy32, 0);
      chk("rst_done32", done32, 0);
      chk("rst_full32", full32, 0);
      chk("rst_full8", full8s, 0);
      chk("rst_done8", done8s, 0);
      rst_n = 1'b1;

      // 32-bit unsigned all-ones square
      @(negedge clk);
      mc32 = 32'hFFFF_FFFF; mp32 = 32'hFFFF_FFFF; mode32 = 1'b0; start32 = 1'b1;
      @(negedge clk);
      start32 = 1'b0;
      wait_done("u32ff", 32, 0, 33);
      chk("u32ff_full", full32, 64'hFFFF_FFFE_0000_0001);
      sel32 = 1'b1; #1;
      chk("u32ff_hi", prod32, 32'hFFFF_FFFE);
      sel32 = 1'b0; #1;
      chk("u32ff_lo", prod32, 32'h0000_0001);

      // signed corner (-128)^2; the signed-disabled twin sees 128*128
      go8(8'h80, 8'h80, 1'b1);
      wait_done("s8min", 8, 0, 9);
      chk("s8min_full", full8s, 16'h4000);
      chk("u8min_full", full8u, 16'h4000);
      chk("u8min_done", done8u, 1);

      // -3 * 7 = -21 signed; 253*7 = 1771 when signed is disabled
      go8(8'hFD, 8'h07, 1'b1);
      wait_done("s8neg", 8, 0, 9);
      chk("s8neg_full", full8s, 16'hFFEB);
      chk("u8neg_full", full8u, 16'h06EB);

      // 0xFF*0xFF: -1*-1 = 1 signed, 65025 with signed disabled
      go8(8'hFF, 8'hFF, 1'b1);
      wait_done("s8ff", 8, 0, 9);
      chk("s8ff_full", full8s, 16'h0001);
      chk("u8ff_full", full8u, 16'hFE01);
      sel8 = 1'b1; #1;
      chk("u8ff_hi", prod8u, 8'hFE);
      sel8 = 1'b0;

      // zero operand still takes full latency
      go8(8'h00, 8'h5A, 1'b0);
      wait_done("zero", 8, 0, 9);
      chk("zero_full", full8s, 16'h0000);

      // start and operand changes during RUN are ignored: 12*11 = 132
      go8(8'h0C, 8'h0B, 1'b0);
      wait_done("ignore", 8, 1, 9);
      chk("ignore_full", full8s, 16'h0084);
      chk("ignore_fullu", full8u, 16'h0084);

      // hold in DONE, then back-to-back start from DONE: 3*5, then 7*9
      go8(8'h03, 8'h05, 1'b0);
      wait_done("b2b1", 8, 0, 9);
      chk("b2b1_full", full8s, 16'd15);
      repeat (3) @(negedge clk);
      chk("hold_done", done8s, 1);
      chk("hold_full", full8s, 16'd15);
      go8(8'h07, 8'h09, 1'b0);
      wait_done("b2b2", 8, 0, 9);
      chk("b2b2_full", full8s, 16'd63);

      // reset at RUN cycle 5 abandons the operation
      go8(8'h0C, 8'h0B, 1'b0);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_run_busy", busy8s, 0);
      chk("rst_run_done", done8s, 0);
      chk("rst_run_full", full8s, 0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done8s) saw_done = 1'b1;
      end
      chk("rst_run_nodone", saw_done, 0);
      rst_n = 1'b1;
      go8(8'h05, 8'h06, 1'b0);
      wait_done("after_rst", 8, 0, 9);
      chk("after_rst_full", full8s, 16'd30);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
